pointwise_mul_sched: RTL and testbench



---
 rtl/pointwise_mul_sched_if.sv | 28 ++
 rtl/pointwise_mul_sched.sv | 113 +++++++++++
 tb/tb_pointwise_mul_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pointwise_mul_sched_if.sv
// Handshake bundle between stream sources, coefficient config and the shared multiplier scheduler.
interface pointwise_mul_sched_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 4
);
   localparam int unsigned IDXW = $clog2(NREQ);

   logic                    cfg_we;
   logic [IDXW-1:0]         cfg_idx;
   logic [WIDTH-1:0]        cfg_coef;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*WIDTH-1:0]   req_data;
   logic [NREQ-1:0]         req_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [IDXW-1:0]         out_id;
   logic                    out_ready;

   modport master (
      output cfg_we, cfg_idx, cfg_coef, req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id
   );

   modport slave (
      input  cfg_we, cfg_idx, cfg_coef, req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id
   );
endinterface

// File: rtl/pointwise_mul_sched.sv
// Round-robin scheduler sharing one WIDTH-bit multiplier between NREQ requesters,
// each scaled by its own programmable coefficient, with a two-stage result pipeline.
module pointwise_mul_sched #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned COEF_RST = 2
) (
   input logic                  clk,
   input logic                  reset,
   pointwise_mul_sched_if.slave bus
);
   localparam int unsigned IDXW = $clog2(NREQ);

   logic [WIDTH-1:0] coef_q [NREQ];
   logic [WIDTH-1:0] coef_d [NREQ];
   logic [IDXW-1:0]  ptr_q, ptr_d;
   logic             s1_v_q, s1_v_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_c_q, s1_c_d;
   logic [IDXW-1:0]  s1_id_q, s1_id_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [IDXW-1:0]  out_id_q, out_id_d;

   logic             grant, accept, adv1, adv2;
   logic [IDXW-1:0]  winner, cand;
   logic [WIDTH-1:0] sel_data;

   // Scan from ptr upward; the index add wraps naturally because NREQ is a power of two.
   always_comb begin
      grant  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = ptr_q + IDXW'(k);
         if (!grant && bus.req_valid[cand]) begin
            grant  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (winner == IDXW'(i)) sel_data = bus.req_data[i*WIDTH +: WIDTH];
      end
   end

   assign adv2   = !out_valid_q || bus.out_ready;
   assign adv1   = !s1_v_q || adv2;
   assign accept = grant && adv1 && !reset;

   assign bus.req_ready = accept ? (NREQ'(1) << winner) : '0;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;

   always_comb begin
      coef_d      = coef_q;
      ptr_d       = ptr_q;
      s1_v_d      = s1_v_q;
      s1_a_d      = s1_a_q;
      s1_c_d      = s1_c_q;
      s1_id_d     = s1_id_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;

      if (bus.cfg_we) coef_d[bus.cfg_idx] = bus.cfg_coef;

      // Stage 1 captures coef_q, so a same-cycle write only affects later accepts.
      if (adv1) begin
         s1_v_d = grant;
         if (grant) begin
            s1_a_d  = sel_data;
            s1_c_d  = coef_q[winner];
            s1_id_d = winner;
            ptr_d   = winner + IDXW'(1);
         end
      end

      if (adv2) begin
         out_valid_d = s1_v_q;
         out_data_d  = s1_a_q * s1_c_q;
         out_id_d    = s1_id_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREQ; i++) coef_q[i] <= WIDTH'(COEF_RST);
         ptr_q       <= '0;
         s1_v_q      <= 1'b0;
         s1_a_q      <= '0;
         s1_c_q      <= '0;
         s1_id_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         coef_q      <= coef_d;
         ptr_q       <= ptr_d;
         s1_v_q      <= s1_v_d;
         s1_a_q      <= s1_a_d;
         s1_c_q      <= s1_c_d;
         s1_id_q     <= s1_id_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end
endmodule

// File: tb/tb_pointwise_mul_sched.sv
// Bench for pointwise_mul_sched: directed scenarios plus random traffic against a
// queue-based model (two-slot FIFO, items visible one edge after acceptance).
module tb_pointwise_mul_sched;
   localparam int WIDTH = 16;
   localparam int NREQ  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pointwise_mul_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   pointwise_mul_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .COEF_RST(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int id;
      int data;
      int acc_cyc;
   } item_t;

   item_t q[$];
   int    seen_data[$];
   int    seen_id[$];
   int    m_coef[NREQ];
   int    m_ptr;
   int    cyc;
   int    errors;
   int    checks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ptr = 0;
      for (int i = 0; i < NREQ; i++) m_coef[i] = 2;
   endtask

   // One clock cycle: check outputs against the model, then advance the model at the edge.
   task automatic step();
      logic [NREQ-1:0] exp_rdy;
      bit              vis, pop, can_acc;
      int              g, idx;
      item_t           it;
      longint          d;
      #1;
      vis = (q.size() > 0) && (q[0].acc_cyc < cyc);
      chk("out_valid", bus.out_valid, vis);
      if (vis) begin
         chk("out_data", bus.out_data, q[0].data);
         chk("out_id", bus.out_id, q[0].id);
      end
      pop     = vis && bus.out_ready;
      can_acc = !reset && (q.size() < 2 || pop);
      g = -1;
      if (can_acc) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && bus.req_valid[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rdy);
      d = (g >= 0) ? longint'(bus.req_data[g*WIDTH +: WIDTH]) : 0;
      @(posedge clk);
      cyc++;
      if (reset) begin
         model_reset();
      end else begin
         if (pop) begin
            seen_data.push_back(q[0].data);
            seen_id.push_back(q[0].id);
            void'(q.pop_front());
         end
         if (g >= 0) begin
            it.id      = g;
            it.data    = int'((d * longint'(m_coef[g])) % 65536);
            it.acc_cyc = cyc;
            q.push_back(it);
            m_ptr = (g + 1) % NREQ;
         end
         if (bus.cfg_we) m_coef[bus.cfg_idx] = int'(bus.cfg_coef);
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.cfg_we    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (n) step();
      reset = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_id", bus.out_id, 0);
      seen_data.delete();
      seen_id.delete();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      model_reset();
      bus.cfg_we    = 1'b0;
      bus.cfg_idx   = '0;
      bus.cfg_coef  = '0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);

      // Reset default: 7 * 2 appears two edges after reset drops
      do_reset(2);
      bus.req_valid = 4'b0001;
      bus.req_data[0 +: WIDTH] = 16'd7;
      step();
      bus.req_valid = '0;
      step();
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_data", bus.out_data, 14);
      chk("t1_id", bus.out_id, 0);
      step();

      // Round robin with all requesters valid
      do_reset(1);
      bus.req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 16'(i + 1);
      repeat (5) step();
      bus.req_valid = '0;
      repeat (3) step();
      chk("rr_count", seen_data.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("rr_id", seen_id[i], i % 4);
         chk("rr_data", seen_data[i], 2 * (i % 4 + 1));
      end

      // Coefficient programming, overflow, same-cycle write
      do_reset(1);
      bus.cfg_we = 1'b1; bus.cfg_idx = 2'd2; bus.cfg_coef = 16'h0100;
      step();
      bus.cfg_we = 1'b0;
      bus.req_valid = 4'b0100;
      bus.req_data[2*WIDTH +: WIDTH] = 16'h0123;
      step();
      bus.req_valid = '0;
      repeat (3) step();
      chk("ovf_data", seen_data[0], 32'h2300);
      chk("ovf_id", seen_id[0], 2);
      seen_data.delete();
      seen_id.delete();
      bus.req_valid = 4'b0010;
      bus.req_data[1*WIDTH +: WIDTH] = 16'd3;
      bus.cfg_we = 1'b1; bus.cfg_idx = 2'd1; bus.cfg_coef = 16'd5;
      step();
      bus.cfg_we = 1'b0;
      step();
      bus.req_valid = '0;
      repeat (3) step();
      chk("cfg_old", seen_data[0], 6);
      chk("cfg_new", seen_data[1], 15);

      // Backpressure
      do_reset(1);
      bus.req_valid = 4'b0001;
      for (int i = 0; i < 9; i++) begin
         bus.out_ready = !(i >= 2 && i < 5);
         bus.req_data[0 +: WIDTH] = 16'(10 + i);
         if (i == 7) bus.req_valid = '0;
         step();
         if (i == 4) begin
            #1;
            chk("bp_stall_ready", bus.req_ready, 0);
         end
      end
      step();
      chk("bp_count", seen_data.size(), 4);
      chk("bp_d0", seen_data[0], 20);
      chk("bp_d1", seen_data[1], 22);
      chk("bp_d2", seen_data[2], 30);
      chk("bp_d3", seen_data[3], 32);

      // Reset while both stages are full
      do_reset(1);
      bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_coef = 16'd9;
      step();
      bus.cfg_we = 1'b0;
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b1111;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 16'd5;
      #1;
      chk("mid_out_valid", bus.out_valid, 0);
      chk("mid_ptr", bus.req_ready, 4'b0001);
      seen_data.delete();
      seen_id.delete();
      step();
      bus.req_valid = '0;
      repeat (3) step();
      chk("mid_count", seen_data.size(), 1);
      chk("mid_data", seen_data[0], 10);

      // Sparse requests: 3 then 1
      do_reset(1);
      bus.req_valid = 4'b1000;
      bus.req_data[3*WIDTH +: WIDTH] = 16'd4;
      #1;
      chk("sp_grant3", bus.req_ready, 4'b1000);
      step();
      bus.req_valid = 4'b0010;
      bus.req_data[1*WIDTH +: WIDTH] = 16'd6;
      #1;
      chk("sp_grant1", bus.req_ready, 4'b0010);
      step();
      bus.req_valid = '0;
      repeat (3) step();
      chk("sp_id0", seen_id[0], 3);
      chk("sp_id1", seen_id[1], 1);

      // Random traffic
      do_reset(1);
      for (int n = 0; n < 400; n++) begin
         reset         = ($urandom_range(0, 63) == 0);
         bus.req_valid = 4'($urandom);
         bus.req_data  = 64'({$urandom, $urandom});
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.cfg_we    = ($urandom_range(0, 7) == 0);
         bus.cfg_idx   = 2'($urandom);
         bus.cfg_coef  = 16'($urandom);
         step();
      end
      reset = 1'b0;
      bus.req_valid = '0;
      bus.cfg_we = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
